// File: rtl/fifo_pkg.sv
// Shared constants and pointer-code helpers for both sides of the async FIFO.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_PTR_WIDTH   = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int MAX_PTR_BITS    = 32;

    // Helpers work on a wide word; callers zero-extend in and truncate out.
    function automatic logic [MAX_PTR_BITS-1:0] gray2bin(input logic [MAX_PTR_BITS-1:0] g);
        logic [MAX_PTR_BITS-1:0] b;
        b[MAX_PTR_BITS-1] = g[MAX_PTR_BITS-1];
        for (int i = MAX_PTR_BITS - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [MAX_PTR_BITS-1:0] bin2gray(input logic [MAX_PTR_BITS-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// Multi-flop synchronizer for a Gray-coded pointer crossing into clk.
module fifo_ptr_sync #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sync_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-side controller of an async FIFO: pointer sync, empty/level, pop strobe, data return.
// Define FIFO_RD_OUTREG_EN to add an output register stage (two-cycle read latency).
module fifo_read_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int PTR_WIDTH   = DEF_PTR_WIDTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                  r_clk,
    input  logic                  rresetn,
    input  logic                  flush,
    input  logic                  rd_enable,
    input  logic [PTR_WIDTH:0]    write_ptr_gray,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [PTR_WIDTH-1:0]  mem_raddr,
    output logic                  fifo_rd_enable,
    output logic [PTR_WIDTH:0]    read_ptr,
    output logic [PTR_WIDTH:0]    read_ptr_gray,
    output logic                  empty,
    output logic [PTR_WIDTH:0]    rd_level,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid
);

    localparam int PW = PTR_WIDTH + 1;

    logic [PW-1:0] wptr_gray_sync;
    logic [PW-1:0] wptr_sync;
    logic [PW-1:0] read_ptr_q, read_ptr_d;
    logic [PW-1:0] read_ptr_gray_q;
    logic          valid_q;

    fifo_ptr_sync #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_wptr_sync (
        .clk   (r_clk),
        .rst_n (rresetn),
        .d_i   (write_ptr_gray),
        .q_o   (wptr_gray_sync)
    );

    assign wptr_sync = PW'(gray2bin(MAX_PTR_BITS'(wptr_gray_sync)));

    assign empty          = (read_ptr_q == wptr_sync);
    assign fifo_rd_enable = rd_enable & ~empty & ~flush;
    assign rd_level       = wptr_sync - read_ptr_q;
    assign mem_raddr      = read_ptr_q[PTR_WIDTH-1:0];

    // Flush has priority; fifo_rd_enable is already masked by flush.
    always_comb begin
        read_ptr_d = read_ptr_q;
        if (flush) begin
            read_ptr_d = '0;
        end else if (fifo_rd_enable) begin
            read_ptr_d = read_ptr_q + PW'(1);
        end
    end

    // Gray pointer registered from the next binary value so the crossing bus never glitches.
    always_ff @(posedge r_clk or negedge rresetn) begin
        if (!rresetn) begin
            read_ptr_q      <= '0;
            read_ptr_gray_q <= '0;
            valid_q         <= 1'b0;
        end else begin
            read_ptr_q      <= read_ptr_d;
            read_ptr_gray_q <= PW'(bin2gray(MAX_PTR_BITS'(read_ptr_d)));
            valid_q         <= fifo_rd_enable;
        end
    end

    assign read_ptr      = read_ptr_q;
    assign read_ptr_gray = read_ptr_gray_q;

`ifdef FIFO_RD_OUTREG_EN
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;

    always_ff @(posedge r_clk or negedge rresetn) begin
        if (!rresetn) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= valid_q;
            if (valid_q) begin
                out_data_q <= mem_rdata;
            end
        end
    end

    assign rd_valid = out_valid_q;
    assign rd_data  = out_data_q;
`else
    // Memory data is valid in the cycle after the strobe; gate it so idle/reset output is zero.
    assign rd_valid = valid_q;
    assign rd_data  = valid_q ? mem_rdata : '0;
`endif

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed self-checking bench for fifo_read_ctrl with a synchronous-read memory model.
module tb_fifo_read_ctrl;

    localparam int DW = 8;
    localparam int PTRW = 4;
`ifdef FIFO_RD_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic            r_clk;
    logic            rresetn;
    logic            flush;
    logic            rd_enable;
    logic [PTRW:0]   write_ptr_gray;
    logic [DW-1:0]   mem_rdata;
    logic [PTRW-1:0] mem_raddr;
    logic            fifo_rd_enable;
    logic [PTRW:0]   read_ptr;
    logic [PTRW:0]   read_ptr_gray;
    logic            empty;
    logic [PTRW:0]   rd_level;
    logic [DW-1:0]   rd_data;
    logic            rd_valid;

    logic [DW-1:0] mem [16];
    logic [DW-1:0] exp_q [$];
    int checks;
    int failures;

    fifo_read_ctrl #(
        .DATA_WIDTH  (DW),
        .PTR_WIDTH   (PTRW),
        .SYNC_STAGES (2)
    ) dut (
        .r_clk          (r_clk),
        .rresetn        (rresetn),
        .flush          (flush),
        .rd_enable      (rd_enable),
        .write_ptr_gray (write_ptr_gray),
        .mem_rdata      (mem_rdata),
        .mem_raddr      (mem_raddr),
        .fifo_rd_enable (fifo_rd_enable),
        .read_ptr       (read_ptr),
        .read_ptr_gray  (read_ptr_gray),
        .empty          (empty),
        .rd_level       (rd_level),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid)
    );

    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    always @(posedge r_clk) begin
        if (fifo_rd_enable) mem_rdata <= mem[mem_raddr];
    end

    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rresetn = 1'b0;
        write_ptr_gray = '0;
        rd_enable = 1'b0;
        flush = 1'b0;
        repeat (3) tick();
        rresetn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rresetn = 1'b0;
        write_ptr_gray = '0;
        rd_enable = 1'b1;
        flush = 1'b0;
        repeat (3) tick();
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_level", 32'(rd_level), 32'd0);
        chk("reset_read_ptr", 32'(read_ptr), 32'd0);
        chk("reset_read_ptr_gray", 32'(read_ptr_gray), 32'd0);
        chk("reset_rd_valid", 32'(rd_valid), 32'd0);
        chk("reset_rd_data", 32'(rd_data), 32'd0);
        chk("reset_strobe", 32'(fifo_rd_enable), 32'd0);
        rresetn = 1'b1;
        tick();
        chk("post_reset_empty", 32'(empty), 32'd1);
        chk("post_reset_strobe", 32'(fifo_rd_enable), 32'd0);
        rd_enable = 1'b0;
    endtask

    task automatic test_sync_latency();
        mem[0] = 8'hA5;
        write_ptr_gray = 5'b00001;
        tick();
        chk("sync_empty_after_1", 32'(empty), 32'd1);
        tick();
        chk("sync_empty_after_2", 32'(empty), 32'd0);
        chk("sync_level", 32'(rd_level), 32'd1);
        rd_enable = 1'b1;
        #1;
        chk("latency_strobe", 32'(fifo_rd_enable), 32'd1);
        chk("latency_raddr", 32'(mem_raddr), 32'd0);
        tick();
        rd_enable = 1'b0;
        #1;
        chk("latency_read_ptr", 32'(read_ptr), 32'd1);
        chk("latency_read_ptr_gray", 32'(read_ptr_gray), 32'd1);
        chk("latency_empty", 32'(empty), 32'd1);
        if (LAT == 2) begin
            chk("latency_valid_early", 32'(rd_valid), 32'd0);
            tick();
        end
        chk("latency_valid", 32'(rd_valid), 32'd1);
        chk("latency_data", 32'(rd_data), 32'hA5);
        tick();
        chk("latency_valid_single", 32'(rd_valid), 32'd0);
    endtask

    task automatic test_drain();
        int strobes;
        int valids;
        do_reset();
        for (int i = 0; i < 16; i++) mem[i] = DW'(8'h10 + i);
        write_ptr_gray = 5'b11000;
        tick();
        tick();
        chk("drain_level", 32'(rd_level), 32'd16);
        strobes = 0;
        valids = 0;
        for (int c = 0; c < 17 + LAT; c++) begin
            rd_enable = (c < 17);
            #1;
            if (fifo_rd_enable) begin
                strobes++;
                exp_q.push_back(mem[mem_raddr]);
            end
            tick();
            if (rd_valid) begin
                valids++;
                if (exp_q.size() == 0) begin
                    chk("drain_unexpected_valid", 32'(rd_data), 32'hFFFF_FFFF);
                end else begin
                    chk("drain_data", 32'(rd_data), 32'(exp_q.pop_front()));
                end
            end
        end
        rd_enable = 1'b0;
        chk("drain_strobes", 32'(strobes), 32'd16);
        chk("drain_valids", 32'(valids), 32'd16);
        chk("drain_read_ptr", 32'(read_ptr), 32'b10000);
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_level_zero", 32'(rd_level), 32'd0);
        rd_enable = 1'b1;
        #1;
        chk("underflow_strobe", 32'(fifo_rd_enable), 32'd0);
        tick();
        rd_enable = 1'b0;
        chk("underflow_read_ptr", 32'(read_ptr), 32'b10000);
    endtask

    task automatic test_wrap();
        write_ptr_gray = 5'b00000;
        tick();
        tick();
        chk("wrap_level", 32'(rd_level), 32'd16);
        rd_enable = 1'b1;
        repeat (15) tick();
        rd_enable = 1'b0;
        #1;
        chk("wrap_ptr_31", 32'(read_ptr), 32'd31);
        chk("wrap_gray_31", 32'(read_ptr_gray), 32'b10000);
        chk("wrap_raddr_15", 32'(mem_raddr), 32'd15);
        chk("wrap_level_1", 32'(rd_level), 32'd1);
        rd_enable = 1'b1;
        tick();
        rd_enable = 1'b0;
        #1;
        chk("wrap_ptr_0", 32'(read_ptr), 32'd0);
        chk("wrap_gray_0", 32'(read_ptr_gray), 32'd0);
        chk("wrap_raddr_0", 32'(mem_raddr), 32'd0);
        chk("wrap_empty", 32'(empty), 32'd1);
        repeat (LAT + 1) tick();
    endtask

    task automatic test_flush();
        write_ptr_gray = 5'b01100;
        tick();
        tick();
        chk("flush_pre_level", 32'(rd_level), 32'd8);
        rd_enable = 1'b1;
        repeat (5) tick();
        #1;
        chk("flush_pre_ptr", 32'(read_ptr), 32'd5);
        chk("flush_pre_gray", 32'(read_ptr_gray), 32'b00111);
        flush = 1'b1;
        #1;
        chk("flush_strobe_masked", 32'(fifo_rd_enable), 32'd0);
        tick();
        flush = 1'b0;
        rd_enable = 1'b0;
        #1;
        chk("flush_read_ptr", 32'(read_ptr), 32'd0);
        chk("flush_read_ptr_gray", 32'(read_ptr_gray), 32'd0);
        chk("flush_rd_valid", 32'(rd_valid), 32'd0);
        chk("flush_level", 32'(rd_level), 32'd8);
        tick();
        chk("flush_rd_valid_after", 32'(rd_valid), 32'd0);
    endtask

    task automatic test_midburst_reset();
        int stray;
        rd_enable = 1'b1;
        tick();
        tick();
        chk("mid_valid_before", 32'(rd_valid), 32'd1);
        #2;
        rresetn = 1'b0;
        write_ptr_gray = '0;
        rd_enable = 1'b0;
        #1;
        chk("mid_valid_async", 32'(rd_valid), 32'd0);
        chk("mid_read_ptr_async", 32'(read_ptr), 32'd0);
        chk("mid_empty_async", 32'(empty), 32'd1);
        tick();
        tick();
        rresetn = 1'b1;
        stray = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rd_valid) stray++;
        end
        chk("mid_no_stray_valid", 32'(stray), 32'd0);
        chk("mid_empty_after", 32'(empty), 32'd1);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rresetn = 1'b1;
        flush = 1'b0;
        rd_enable = 1'b0;
        write_ptr_gray = '0;
        mem_rdata = '0;
        for (int i = 0; i < 16; i++) mem[i] = DW'($urandom_range(0, 255));
        #2;
        test_reset();
        test_sync_latency();
        test_drain();
        test_wrap();
        test_flush();
        test_midburst_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
